// File: rtl/tpg_pattern_sequencer.sv
// Test-pattern sequencer: picks one of NUM_PAT generator words, cycles patterns
// automatically per frame count or on manual request, switching only at frame ends.
module tpg_pattern_sequencer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_PAT    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  auto_i,
  input  logic [7:0]            frames_per_pat_i,
  input  logic                  req_i,
  input  logic [2:0]            pat_req_i,
  input  logic                  valid_i,
  input  logic                  end_of_video_i,
  input  logic [DATA_WIDTH-1:0] data_stndrt_i,
  input  logic [DATA_WIDTH-1:0] data_offset_i,
  input  logic [DATA_WIDTH-1:0] data_grad_i,
  input  logic [DATA_WIDTH-1:0] data_onecolor_i,
  input  logic [DATA_WIDTH-1:0] data_imag_i,
  output logic                  tpg_enable_o,
  output logic                  handshake_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [2:0]            pattern_o,
  output logic                  change_ack_o,
  output logic                  err_o
);

  localparam int unsigned PW      = 3;
  localparam int unsigned CW      = 8;
  localparam logic [PW-1:0] PAT_MAX = PW'(NUM_PAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWITCH} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [PW-1:0]   lat_q, lat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, sel_c;
  logic            tpg_en_q, hs_q, ack_q, err_q, valid_q;
  logic            req_ok_c, req_bad_c, auto_due_c;
  logic [PW-1:0]   pat_inc_c;

  // Request validity and auto-switch condition
  assign req_ok_c   = req_i && ({1'b0, pat_req_i} < 4'(NUM_PAT));
  assign req_bad_c  = req_i && !req_ok_c;
  assign auto_due_c = auto_i && (frames_per_pat_i != 8'd0) && end_of_video_i
                      && (cnt_q == frames_per_pat_i - 8'd1);
  assign pat_inc_c  = (pat_q >= PAT_MAX) ? '0 : pat_q + 3'd1;

  // Next-state, pattern, latch and frame counter
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        lat_d = '0;
        if (req_ok_c) pat_d = pat_req_i;
        if (start_i)  state_d = RUN;
      end
      RUN: begin
        if (req_ok_c && auto_due_c) begin
          pat_d   = pat_req_i;
          state_d = SWITCH;
        end else if (req_ok_c) begin
          lat_d   = pat_req_i;
          state_d = DRAIN;
        end else if (auto_due_c) begin
          pat_d   = pat_inc_c;
          state_d = SWITCH;
        end
      end
      DRAIN: begin
        if (end_of_video_i) begin
          pat_d   = req_ok_c ? pat_req_i : lat_q;
          state_d = SWITCH;
        end else if (req_ok_c) begin
          lat_d = pat_req_i;
        end
      end
      SWITCH: state_d = RUN;
      default: state_d = IDLE;
    endcase
    // Stop overrides everything and drops any pending request
    if (stop_i) begin
      state_d = IDLE;
      pat_d   = pat_q;
      lat_d   = '0;
    end
    if (state_d == IDLE || state_d == SWITCH) begin
      cnt_d = '0;
    end else if ((state_q == RUN || state_q == DRAIN) && end_of_video_i
                 && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Pixel source selected by the active pattern
  always_comb begin
    sel_c = data_stndrt_i;
    case (pat_q)
      3'd1:    sel_c = data_offset_i;
      3'd2:    sel_c = data_grad_i;
      3'd3:    sel_c = data_onecolor_i;
      3'd4:    sel_c = data_imag_i;
      default: sel_c = data_stndrt_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      lat_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      tpg_en_q <= 1'b0;
      hs_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      tpg_en_q <= (state_d != IDLE);
      hs_q     <= (state_d == DRAIN);
      ack_q    <= (state_d == SWITCH);
      err_q    <= req_bad_c;
      valid_q  <= valid_i && (state_q != IDLE);
      if (valid_i) data_q <= sel_c;
    end
  end

  assign tpg_enable_o = tpg_en_q;
  assign handshake_o  = hs_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign pattern_o    = pat_q;
  assign change_ack_o = ack_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_tpg_pattern_sequencer.sv
// Scoreboard bench for tpg_pattern_sequencer: directed stimulus queues expected
// pixels, switch acks and error pulses; negedge monitors pop and compare.
module tb_tpg_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, auto_i = 1'b0;
  logic [7:0]  frames_per_pat_i = 8'd0;
  logic        req_i = 1'b0;
  logic [2:0]  pat_req_i = 3'd0;
  logic        valid_i = 1'b0, end_of_video_i = 1'b0;
  logic [23:0] d0 = 24'hFFFFFF, d1 = 24'h111111, d2 = 24'h222222,
               d3 = 24'h333333, d4 = 24'h444444;
  logic        tpg_enable_o, handshake_o, valid_o, change_ack_o, err_o;
  logic [23:0] data_o;
  logic [2:0]  pattern_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [23:0] data_q_exp[$];
  logic [2:0]  ack_q_exp[$];
  logic [2:0]  err_q_exp[$];

  tpg_pattern_sequencer #(.DATA_WIDTH(24), .NUM_PAT(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .auto_i(auto_i), .frames_per_pat_i(frames_per_pat_i), .req_i(req_i),
    .pat_req_i(pat_req_i), .valid_i(valid_i), .end_of_video_i(end_of_video_i),
    .data_stndrt_i(d0), .data_offset_i(d1), .data_grad_i(d2),
    .data_onecolor_i(d3), .data_imag_i(d4),
    .tpg_enable_o(tpg_enable_o), .handshake_o(handshake_o), .data_o(data_o),
    .valid_o(valid_o), .pattern_o(pattern_o), .change_ack_o(change_ack_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pdata(input int p);
    case (p)
      0: return 24'hFFFFFF;
      1: return 24'h111111;
      2: return 24'h222222;
      3: return 24'h333333;
      default: return 24'h444444;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle of generator activity; expected pixel pushed when it will be forwarded
  task automatic cyc(input bit v, input bit e, input int p);
    valid_i = v;
    end_of_video_i = e;
    if (v) data_q_exp.push_back(pdata(p));
    step();
    valid_i = 1'b0;
    end_of_video_i = 1'b0;
  endtask

  // Pixel monitor
  always @(negedge clk) begin
    if (mon_en && valid_o) begin
      n_cmp++;
      if (data_q_exp.size() == 0) begin
        n_bad++;
        $display("FAIL pixel_unexpected: got %0h expected none", data_o);
      end else begin
        logic [23:0] e;
        e = data_q_exp.pop_front();
        if (data_o !== e) begin
          n_bad++;
          $display("FAIL pixel: got %0h expected %0h", data_o, e);
        end
      end
    end
  end

  // Switch-ack monitor
  always @(negedge clk) begin
    if (mon_en && change_ack_o) begin
      n_cmp++;
      if (ack_q_exp.size() == 0) begin
        n_bad++;
        $display("FAIL ack_unexpected: got pattern %0d expected no ack", pattern_o);
      end else begin
        logic [2:0] e;
        e = ack_q_exp.pop_front();
        if (pattern_o !== e) begin
          n_bad++;
          $display("FAIL ack_pattern: got %0d expected %0d", pattern_o, e);
        end
      end
    end
  end

  // Error-pulse monitor
  always @(negedge clk) begin
    if (mon_en && err_o) begin
      n_cmp++;
      if (err_q_exp.size() == 0) begin
        n_bad++;
        $display("FAIL err_unexpected: got err=1 expected 0");
      end else begin
        logic [2:0] e;
        e = err_q_exp.pop_front();
        if (pattern_o !== e || handshake_o !== 1'b0) begin
          n_bad++;
          $display("FAIL err_state: got pattern %0d hs %0b expected pattern %0d hs 0",
                   pattern_o, handshake_o, e);
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_tpg_enable", 32'(tpg_enable_o), 0);
    chk("rst_handshake",  32'(handshake_o), 0);
    chk("rst_valid",      32'(valid_o), 0);
    chk("rst_pattern",    32'(pattern_o), 0);
    chk("rst_ack",        32'(change_ack_o), 0);
    chk("rst_err",        32'(err_o), 0);
    chk("rst_data",       32'(data_o), 0);
    rst_i = 1'b1;
    mon_en = 1'b1;

    // Start, then standard-pattern pixels
    start_i = 1'b1;
    step();
    chk("start_tpg_enable", 32'(tpg_enable_o), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Auto cycling every 2 frames through 1,2,3,4 and wrapping to 0
    auto_i = 1'b1;
    frames_per_pat_i = 8'd2;
    for (int f = 0; f < 10; f++) begin
      cyc(1, 0, (f / 2) % 5);
      if (f % 2 == 1) ack_q_exp.push_back(3'((f + 1) / 2 % 5));
      cyc(1, 1, (f / 2) % 5);
    end
    chk("auto_wrap_pattern", 32'(pattern_o), 0);
    auto_i = 1'b0;

    // Manual request mid-frame: drain until frame end
    cyc(1, 0, 0);
    req_i = 1'b1; pat_req_i = 3'd3;
    cyc(1, 0, 0);
    req_i = 1'b0;
    chk("drain_handshake", 32'(handshake_o), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("drain_handshake_hold", 32'(handshake_o), 1);
    chk("drain_pattern_old", 32'(pattern_o), 0);
    ack_q_exp.push_back(3'd3);
    cyc(1, 1, 0);
    chk("switch_pattern", 32'(pattern_o), 3);
    chk("switch_handshake", 32'(handshake_o), 0);
    cyc(1, 0, 3);
    cyc(1, 0, 3);

    // Invalid request
    req_i = 1'b1; pat_req_i = 3'd6;
    err_q_exp.push_back(3'd3);
    step();
    req_i = 1'b0;
    chk("bad_req_pattern", 32'(pattern_o), 3);
    chk("bad_req_handshake", 32'(handshake_o), 0);
    step();

    // Auto due and manual request in the same cycle: manual wins, one ack
    auto_i = 1'b1;
    frames_per_pat_i = 8'd1;
    req_i = 1'b1; pat_req_i = 3'd4;
    ack_q_exp.push_back(3'd4);
    cyc(1, 1, 3);
    req_i = 1'b0;
    auto_i = 1'b0;
    chk("collide_pattern", 32'(pattern_o), 4);
    chk("collide_handshake", 32'(handshake_o), 0);
    cyc(1, 0, 4);

    // Stop while draining
    req_i = 1'b1; pat_req_i = 3'd1;
    step();
    req_i = 1'b0;
    chk("drain2_handshake", 32'(handshake_o), 1);
    stop_i = 1'b1;
    step();
    chk("stop_tpg_enable", 32'(tpg_enable_o), 0);
    chk("stop_handshake", 32'(handshake_o), 0);
    chk("stop_pattern", 32'(pattern_o), 4);
    valid_i = 1'b1; end_of_video_i = 1'b1;
    step();
    valid_i = 1'b0; end_of_video_i = 1'b0;
    stop_i = 1'b0;
    step();
    chk("restart_tpg_enable", 32'(tpg_enable_o), 1);
    cyc(1, 1, 4);
    cyc(1, 0, 4);
    chk("restart_pattern", 32'(pattern_o), 4);

    // Direct pattern load while idle
    stop_i = 1'b1;
    step();
    stop_i = 1'b0; start_i = 1'b0;
    req_i = 1'b1; pat_req_i = 3'd2;
    step();
    req_i = 1'b0;
    chk("idle_load_pattern", 32'(pattern_o), 2);
    chk("idle_tpg_enable", 32'(tpg_enable_o), 0);

    // Reset in the middle of a drain
    start_i = 1'b1;
    step();
    req_i = 1'b1; pat_req_i = 3'd0;
    step();
    req_i = 1'b0;
    chk("drain3_handshake", 32'(handshake_o), 1);
    rst_i = 1'b0;
    step();
    chk("midrst_pattern", 32'(pattern_o), 0);
    chk("midrst_handshake", 32'(handshake_o), 0);
    chk("midrst_tpg_enable", 32'(tpg_enable_o), 0);
    rst_i = 1'b1;
    step();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (4) step();

    chk("leftover_pixels", 32'(data_q_exp.size()), 0);
    chk("leftover_acks",   32'(ack_q_exp.size()), 0);
    chk("leftover_errs",   32'(err_q_exp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpg_pattern_sequencer.md
TPG_PATTERN_SEQUENCER -- requirements
Module: tpg_pattern_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, pixel word width.
REQ-002 SHALL have parameter NUM_PAT, default 5, number of selectable patterns (codes 0..NUM_PAT-1).
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 start_i  in  1  level; leave IDLE and run the generator.
REQ-006 stop_i  in  1  level; return to IDLE.
REQ-007 auto_i  in  1  1 = auto-cycle patterns; 0 = manual only.
REQ-008 frames_per_pat_i  in  8  frames per pattern in auto mode; 0 disables auto switching.
REQ-009 req_i  in  1  one-cycle manual pattern-change request.
REQ-010 pat_req_i  in  3  requested pattern code, sampled with req_i.
REQ-011 valid_i  in  1  generator pixel valid.
REQ-012 end_of_video_i  in  1  generator frame-end pulse.
REQ-013 data_stndrt_i, data_offset_i, data_grad_i, data_onecolor_i, data_imag_i  in  DATA_WIDTH each  generator pattern words, codes 0..4 in that order.
REQ-014 tpg_enable_o  out  1  generator enable.
REQ-015 handshake_o  out  1  to generator handshake input; requests frame-end indication.
REQ-016 data_o  out  DATA_WIDTH  selected pixel.
REQ-017 valid_o  out  1  data_o qualifier.
REQ-018 pattern_o  out  3  active pattern code.
REQ-019 change_ack_o  out  1  one-cycle pulse when a pattern switch takes effect.
REQ-020 err_o  out  1  one-cycle pulse on an invalid request.

Function
REQ-021 FSM states SHALL be IDLE, RUN, DRAIN, SWITCH.
REQ-022 IDLE: tpg_enable_o=0, valid_o=0; start_i=1 and stop_i=0 -> RUN next cycle.
REQ-023 stop_i=1 in any state -> IDLE next cycle; priority over all other events; pending request discarded; pattern_o retained.
REQ-024 RUN/DRAIN/SWITCH: tpg_enable_o=1.
REQ-025 frame_cnt (8 bit, internal) SHALL increment on end_of_video_i=1 in RUN/DRAIN; it clears in SWITCH and in IDLE; it saturates at 255.
REQ-026 Auto switch: in RUN, auto_i=1, frames_per_pat_i!=0, end_of_video_i=1 and frame_cnt==frames_per_pat_i-1 -> SWITCH with next = pattern_o+1, wrapping NUM_PAT-1 -> 0.
REQ-027 Manual: req_i=1 with pat_req_i<NUM_PAT in RUN -> latch code, go to DRAIN; req_i in DRAIN overwrites latch (last wins).
REQ-028 req_i with pat_req_i>=NUM_PAT -> err_o pulse next cycle; request ignored; state unchanged.
REQ-029 req_i=1 in IDLE -> pattern_o updated directly next cycle, no change_ack_o.
REQ-030 DRAIN: handshake_o=1; end_of_video_i=1 -> SWITCH with latched code; handshake_o=0 in all other states.
REQ-031 Simultaneous manual req_i and auto-switch condition in the same cycle: manual wins; FSM goes directly to SWITCH with pat_req_i.
REQ-032 SWITCH lasts exactly one cycle: pattern_o <= next code, change_ack_o=1, frame_cnt <= 0, then RUN.
REQ-033 Request equal to current pattern SHALL still pass through DRAIN/SWITCH and pulse change_ack_o.
REQ-034 Datapath: data_o registered, 1-cycle latency; data_o <= input selected by pattern_o when valid_i=1, else held.
REQ-035 valid_o <= valid_i when state!=IDLE, else 0.
REQ-036 Pattern change SHALL never split a frame: pixels after the switching end_of_video_i use the new code, all earlier pixels the old code.

Reset
REQ-037 rst_i=0 at clock edge: state=IDLE, pattern_o=0, frame_cnt=0, latched code=0, tpg_enable_o=0, handshake_o=0, data_o=0, valid_o=0, change_ack_o=0, err_o=0.
REQ-038 Reset mid-frame or mid-DRAIN SHALL abandon pending request; no change_ack_o after reset release.

Verification
REQ-039 Reset, start_i=1, valid_i=1, data_stndrt_i=0xFFFFFF -> tpg_enable_o=1 one cycle after start; data_o=0xFFFFFF, valid_o=1 one cycle after valid_i.
REQ-040 auto_i=1, frames_per_pat_i=2, four end_of_video_i pulses -> pattern_o 0->1 after 2nd, 1->2 after 4th; change_ack_o pulses twice; pattern 4 wraps to 0.
REQ-041 RUN, req_i with pat_req_i=3 mid-frame -> handshake_o=1 until end_of_video_i; pattern_o=3 and change_ack_o one cycle after SWITCH; data_o unchanged source before.
REQ-042 req_i with pat_req_i=6 -> err_o=1 for one cycle, pattern_o unchanged, handshake_o stays 0.
REQ-043 Auto switch due and req_i pat_req_i=4 in same cycle -> pattern_o=4, single change_ack_o.
REQ-044 stop_i=1 while in DRAIN -> IDLE next cycle, tpg_enable_o=0, handshake_o=0, no change_ack_o, pattern_o unchanged.
